// File: rtl/sap_pkg.sv
// Shared SAP-1 control definitions: opcodes, T-states, control-word bits and words.
package sap_pkg;

  localparam int unsigned STATE_W = 6;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned CON_W   = 12;

  // One-hot T-states as produced by ring_counter (bit0 = T1).
  typedef enum logic [STATE_W-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  // Instruction-register opcodes; anything else decodes as NOP.
  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // Bit positions inside the control word {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}.
  localparam int unsigned CON_CP   = 11;
  localparam int unsigned CON_EP   = 10;
  localparam int unsigned CON_LM_N = 9;
  localparam int unsigned CON_CE_N = 8;
  localparam int unsigned CON_LI_N = 7;
  localparam int unsigned CON_EI_N = 6;
  localparam int unsigned CON_LA_N = 5;
  localparam int unsigned CON_EA   = 4;
  localparam int unsigned CON_SU   = 3;
  localparam int unsigned CON_EU   = 2;
  localparam int unsigned CON_LB_N = 1;
  localparam int unsigned CON_LO_N = 0;

  // Named control words (active-low loads/enables parked high in idle).
  localparam logic [CON_W-1:0] CW_IDLE    = 12'h3E3;
  localparam logic [CON_W-1:0] CW_FETCH1  = 12'h5E3; // Ep, Lm
  localparam logic [CON_W-1:0] CW_FETCH2  = 12'hBE3; // Cp
  localparam logic [CON_W-1:0] CW_FETCH3  = 12'h263; // CE, Li
  localparam logic [CON_W-1:0] CW_IR_MAR  = 12'h1A3; // Lm, Ei
  localparam logic [CON_W-1:0] CW_LDA_T5  = 12'h2C3; // CE, La
  localparam logic [CON_W-1:0] CW_ALU_T5  = 12'h2E1; // CE, Lb
  localparam logic [CON_W-1:0] CW_ADD_T6  = 12'h3C7; // La, Eu
  localparam logic [CON_W-1:0] CW_SUB_T6  = 12'h3CF; // La, Eu, Su
  localparam logic [CON_W-1:0] CW_OUT_T4  = 12'h3F2; // Ea, Lo

  // Ring successor of a T-state; anything unexpected restarts at T1.
  function automatic tstate_e next_phase(input tstate_e cur);
    case (cur)
      T1:      return T2;
      T2:      return T3;
      T3:      return T4;
      T4:      return T5;
      T5:      return T6;
      default: return T1;
    endcase
  endfunction

endpackage

// File: rtl/con_rom.sv
// Combinational microcode table: T-state + opcode -> control word.
module con_rom
  import sap_pkg::*;
(
  input  logic [STATE_W-1:0] phase_i,
  input  logic [OP_W-1:0]    opcode_i,
  input  logic               idle_i,
  output logic [CON_W-1:0]   con_o
);

  // Word lookup; idle, non-one-hot or unknown phase parks on the idle word.
  always_comb begin
    con_o = CW_IDLE;
    if (!idle_i) begin
      case (phase_i)
        T1: con_o = CW_FETCH1;
        T2: con_o = CW_FETCH2;
        T3: con_o = CW_FETCH3;
        T4: begin
          case (opcode_i)
            OP_LDA, OP_ADD, OP_SUB: con_o = CW_IR_MAR;
            OP_OUT:                 con_o = CW_OUT_T4;
            default:                con_o = CW_IDLE;
          endcase
        end
        T5: begin
          case (opcode_i)
            OP_LDA:         con_o = CW_LDA_T5;
            OP_ADD, OP_SUB: con_o = CW_ALU_T5;
            default:        con_o = CW_IDLE;
          endcase
        end
        T6: begin
          case (opcode_i)
            OP_ADD:  con_o = CW_ADD_T6;
            OP_SUB:  con_o = CW_SUB_T6;
            default: con_o = CW_IDLE;
          endcase
        end
        default: con_o = CW_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 control sequencer: microcode word output plus halt, ring-error and retire tracking.
module control_sequencer
  import sap_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [STATE_W-1:0] state,
  input  logic [OP_W-1:0]    opcode,
  output logic [CON_W-1:0]   con,
  output logic               hlt,
  output logic               err,
  output logic [CNT_W-1:0]   instr_cnt
);

  logic             hlt_q, hlt_d;
  logic             err_q, err_d;
  tstate_e          phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_hit;
  logic             mismatch;

  // Control word straight from the current inputs; halt or error forces idle.
  con_rom u_con_rom (
    .phase_i  (state),
    .opcode_i (opcode),
    .idle_i   (hlt_q | err_q),
    .con_o    (con)
  );

  // Next-state: halt wins over a same-edge mismatch; error freezes phase and count.
  always_comb begin
    hlt_d    = hlt_q;
    err_d    = err_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    halt_hit = (state == T4) && (opcode == OP_HLT);
    mismatch = (state != phase_q);
    if (!hlt_q) begin
      if (halt_hit) begin
        hlt_d = 1'b1;
      end else if (mismatch) begin
        err_d = 1'b1;
      end
      if (!err_q) begin
        phase_d = next_phase(phase_q);
        if (state == T6) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low clear taking priority.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      hlt_q   <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= T1;
      cnt_q   <= '0;
    end else begin
      hlt_q   <= hlt_d;
      err_q   <= err_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hlt       = hlt_q;
  assign err       = err_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes expectations, negedge monitor checks.
module tb_control_sequencer;

  logic        clk;
  logic        clr_n;
  logic [5:0]  state;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic        hlt;
  logic        err;
  logic [7:0]  instr_cnt;

  control_sequencer #(.CNT_W(8)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .state     (state),
    .opcode    (opcode),
    .con       (con),
    .hlt       (hlt),
    .err       (err),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          seq;
    logic [11:0] con;
    logic        hlt;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   seq   = 0;

  logic       e_hlt = 1'b0;
  logic       e_err = 1'b0;
  logic [7:0] e_cnt = 8'd0;

  // Hand-written microcode table.
  function automatic logic [11:0] exp_word(input logic [3:0] op, input int k);
    logic [11:0] w;
    w = 12'h3E3;
    case (k)
      0: w = 12'h5E3;
      1: w = 12'hBE3;
      2: w = 12'h263;
      3: case (op)
           4'h0, 4'h1, 4'h2: w = 12'h1A3;
           4'hE:             w = 12'h3F2;
           default:          w = 12'h3E3;
         endcase
      4: case (op)
           4'h0:       w = 12'h2C3;
           4'h1, 4'h2: w = 12'h2E1;
           default:    w = 12'h3E3;
         endcase
      5: case (op)
           4'h1:    w = 12'h3C7;
           4'h2:    w = 12'h3CF;
           default: w = 12'h3E3;
         endcase
      default: w = 12'h3E3;
    endcase
    return w;
  endfunction

  // Drive one cycle of inputs, queue what the outputs must show, then cross the edge.
  task automatic cyc(input logic rn, input logic [5:0] st, input logic [3:0] op,
                     input logic [11:0] ec);
    exp_t e;
    clr_n  = rn;
    state  = st;
    opcode = op;
    e.seq = seq;
    e.con = ec;
    e.hlt = e_hlt;
    e.err = e_err;
    e.cnt = e_cnt;
    q.push_back(e);
    seq++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 6'b000001, 4'h0, (e_hlt || e_err) ? 12'h3E3 : 12'h5E3);
    e_hlt = 1'b0;
    e_err = 1'b0;
    e_cnt = 8'd0;
  endtask

  // One instruction with the ring counter in lockstep.
  task automatic run_instr(input logic [3:0] op);
    logic [5:0]  st;
    logic [11:0] ec;
    for (int k = 0; k < 6; k++) begin
      st = 6'(1 << k);
      ec = (e_hlt || e_err) ? 12'h3E3 : exp_word(op, k);
      cyc(1'b1, st, op, ec);
      if (!e_hlt) begin
        if (k == 3 && op == 4'hF) e_hlt = 1'b1;
        else if (k == 5 && !e_err) e_cnt = e_cnt + 8'd1;
      end
    end
  endtask

  // Monitor: compare every queued expectation against the outputs mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (con !== e.con) begin
        bad++;
        $display("FAIL con seq=%0d got=%h exp=%h", e.seq, con, e.con);
      end
      total++;
      if (hlt !== e.hlt) begin
        bad++;
        $display("FAIL hlt seq=%0d got=%b exp=%b", e.seq, hlt, e.hlt);
      end
      total++;
      if (err !== e.err) begin
        bad++;
        $display("FAIL err seq=%0d got=%b exp=%b", e.seq, err, e.err);
      end
      total++;
      if (instr_cnt !== e.cnt) begin
        bad++;
        $display("FAIL instr_cnt seq=%0d got=%0d exp=%0d", e.seq, instr_cnt, e.cnt);
      end
    end
  end

  initial begin
    clr_n  = 1'b0;
    state  = 6'b000001;
    opcode = 4'h0;
    @(posedge clk);
    #1;
    do_reset();

    // Program: LDA ADD SUB OUT HLT; ends with hlt=1 and four retired.
    run_instr(4'h0);
    run_instr(4'h1);
    run_instr(4'h2);
    run_instr(4'hE);
    run_instr(4'hF);

    // Halted: arbitrary states and opcodes leave everything frozen.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), 12'h3E3);
    end

    // Ring fault in T2 after one retired instruction.
    do_reset();
    run_instr(4'h0);
    cyc(1'b1, 6'b000001, 4'h5, 12'h5E3);
    cyc(1'b1, 6'b000011, 4'h5, 12'h3E3);
    e_err = 1'b1;
    cyc(1'b1, 6'b000100, 4'h5, 12'h3E3);
    cyc(1'b1, 6'b001000, 4'h5, 12'h3E3);
    cyc(1'b1, 6'b010000, 4'h5, 12'h3E3);
    cyc(1'b1, 6'b100000, 4'h5, 12'h3E3);
    run_instr(4'h1);

    // HLT decode coinciding with a ring mismatch: halt, not error.
    do_reset();
    cyc(1'b1, 6'b000001, 4'hF, 12'h5E3);
    cyc(1'b1, 6'b000010, 4'hF, 12'hBE3);
    cyc(1'b1, 6'b001000, 4'hF, 12'h3E3);
    e_hlt = 1'b1;
    cyc(1'b1, 6'b010000, 4'hF, 12'h3E3);
    cyc(1'b1, 6'b100000, 4'hF, 12'h3E3);

    // Reset during ADD T5, then a clean instruction from T1.
    do_reset();
    run_instr(4'h0);
    cyc(1'b1, 6'b000001, 4'h1, 12'h5E3);
    cyc(1'b1, 6'b000010, 4'h1, 12'hBE3);
    cyc(1'b1, 6'b000100, 4'h1, 12'h263);
    cyc(1'b1, 6'b001000, 4'h1, 12'h1A3);
    cyc(1'b0, 6'b010000, 4'h1, 12'h2E1);
    e_cnt = 8'd0;
    run_instr(4'h0);
    run_instr(4'h2);

    // 256 NOPs wrap the 8-bit counter back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) run_instr(4'h5);
    cyc(1'b1, 6'b000001, 4'h5, 12'h5E3);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
